// File: rtl/frame_defs.sv
`default_nettype none
// ============================================================================
//  Module      : frame_defs (package)
//  Description : Shared definitions for the frame builder and its downstream
//                checker: FSM state encoding, header/overhead sizes and the
//                XOR checksum update function.
//  Revision    : 1.0 - initial release
// ============================================================================
package frame_defs;

    // Builder FSM states, one per frame field.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,  // waiting for a command, loads the dest byte
        ST_SRC     = 3'd1,  // loads the source address byte
        ST_LEN     = 3'd2,  // loads the payload length byte
        ST_PAYLOAD = 3'd3,  // forwards payload bytes
        ST_CSUM    = 3'd4   // loads the trailing checksum byte
    } frame_state_t;

    // Header is dest, src, len; overhead adds the checksum byte.
    localparam int FRAME_HDR_LEN  = 3;
    localparam int FRAME_OVERHEAD = 4;

    // Running checksum: XOR of every byte of the frame seen so far.
    function automatic logic [7:0] csum_update(input logic [7:0] csum,
                                               input logic [7:0] data);
        return csum ^ data;
    endfunction

endpackage : frame_defs
`default_nettype wire

// File: rtl/frame_out_reg.sv
`default_nettype none
// ============================================================================
//  Module      : frame_out_reg
//  Description : Single-entry output register for the 8-bit frame interface.
//                Accepts a load request from the builder whenever it is empty
//                or its current byte is being taken downstream, so one byte
//                per cycle flows under continuous readiness.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                load, load_data,
//                load_sof, load_eof  - byte offered by the builder this cycle
//                load_en             - register can take a byte this cycle
//                out_*               - registered frame interface
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_out_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       load_sof,
    input  logic       load_eof,
    output logic       load_en,
    output logic [7:0] out_data,
    output logic       out_sof,
    output logic       out_eof,
    output logic       out_src_rdy,
    input  logic       out_dst_rdy
);

    logic [7:0] r_data;
    logic       r_sof;
    logic       r_eof;
    logic       r_full;

    // Empty, or the held byte leaves this cycle: a new byte may replace it.
    assign load_en = !r_full || out_dst_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= 8'h00;
            r_sof  <= 1'b0;
            r_eof  <= 1'b0;
            r_full <= 1'b0;
        end else if (load_en) begin
            if (load) begin
                r_data <= load_data;
                r_sof  <= load_sof;
                r_eof  <= load_eof;
                r_full <= 1'b1;
            end else begin
                // Byte (if any) went downstream and nothing replaces it.
                r_full <= 1'b0;
            end
        end
    end

    assign out_data    = r_data;
    assign out_sof     = r_sof;
    assign out_eof     = r_eof;
    assign out_src_rdy = r_full;

endmodule : frame_out_reg
`default_nettype wire

// File: rtl/frame_builder.sv
`default_nettype none
// ============================================================================
//  Module      : frame_builder
//  Description : Builds one frame per command: dest, SRC_ADDR, len, payload,
//                XOR checksum. Output is registered, honours backpressure and
//                runs gapless back-to-back frames at one byte per cycle.
//  Ports       : clk, rst                       - clock, sync active-high reset
//                cmd_valid/cmd_dest/cmd_len/
//                cmd_ready                      - per-frame command handshake
//                pl_data/pl_valid/pl_ready      - payload byte stream
//                out_data/out_sof/out_eof/
//                out_src_rdy/out_dst_rdy        - frame output interface
//                frame_cnt                      - completed frame count
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_builder
    import frame_defs::*;
#(
    parameter logic [7:0] SRC_ADDR = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [7:0]  cmd_dest,
    input  logic [7:0]  cmd_len,
    output logic        cmd_ready,
    input  logic [7:0]  pl_data,
    input  logic        pl_valid,
    output logic        pl_ready,
    output logic [7:0]  out_data,
    output logic        out_sof,
    output logic        out_eof,
    output logic        out_src_rdy,
    input  logic        out_dst_rdy,
    output logic [15:0] frame_cnt
);

    frame_state_t r_state;
    logic [7:0]   r_len;
    logic [7:0]   r_remaining;
    logic [7:0]   r_csum;
    logic [15:0]  r_frame_cnt;

    logic         w_load_en;
    logic         w_load;
    logic [7:0]   w_load_data;
    logic         w_load_sof;
    logic         w_load_eof;
    logic         w_advance;

    // Byte offered to the output register in the current state.
    always_comb begin
        w_load      = 1'b0;
        w_load_data = 8'h00;
        w_load_sof  = 1'b0;
        w_load_eof  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_load      = cmd_valid;
                w_load_data = cmd_dest;
                w_load_sof  = 1'b1;
            end
            ST_SRC: begin
                w_load      = 1'b1;
                w_load_data = SRC_ADDR;
            end
            ST_LEN: begin
                w_load      = 1'b1;
                w_load_data = r_len;
            end
            ST_PAYLOAD: begin
                w_load      = pl_valid;
                w_load_data = pl_data;
            end
            ST_CSUM: begin
                w_load      = 1'b1;
                w_load_data = r_csum;
                w_load_eof  = 1'b1;
            end
            default: begin
                w_load = 1'b0;
            end
        endcase
    end

    assign cmd_ready = w_load_en && (r_state == ST_IDLE);
    assign pl_ready  = w_load_en && (r_state == ST_PAYLOAD);
    assign w_advance = w_load_en && w_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_len       <= 8'h00;
            r_remaining <= 8'h00;
            r_csum      <= 8'h00;
            r_frame_cnt <= 16'h0000;
        end else begin
            // Count on the eof transfer itself, so a stalled eof is not counted.
            if (out_src_rdy && out_dst_rdy && out_eof) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if (w_advance) begin
                case (r_state)
                    ST_IDLE: begin
                        r_len   <= cmd_len;
                        r_csum  <= cmd_dest;
                        r_state <= ST_SRC;
                    end
                    ST_SRC: begin
                        r_csum  <= csum_update(r_csum, SRC_ADDR);
                        r_state <= ST_LEN;
                    end
                    ST_LEN: begin
                        r_csum      <= csum_update(r_csum, r_len);
                        r_remaining <= r_len;
                        r_state     <= (r_len != 8'h00) ? ST_PAYLOAD : ST_CSUM;
                    end
                    ST_PAYLOAD: begin
                        r_csum      <= csum_update(r_csum, pl_data);
                        r_remaining <= r_remaining - 8'd1;
                        if (r_remaining == 8'd1) begin
                            r_state <= ST_CSUM;
                        end
                    end
                    ST_CSUM: begin
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign frame_cnt = r_frame_cnt;

    frame_out_reg u_out_reg (
        .clk         (clk),
        .rst         (rst),
        .load        (w_load),
        .load_data   (w_load_data),
        .load_sof    (w_load_sof),
        .load_eof    (w_load_eof),
        .load_en     (w_load_en),
        .out_data    (out_data),
        .out_sof     (out_sof),
        .out_eof     (out_eof),
        .out_src_rdy (out_src_rdy),
        .out_dst_rdy (out_dst_rdy)
    );

endmodule : frame_builder
`default_nettype wire

// File: tb/tb_frame_builder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_builder
//  Description : Self-checking bench for frame_builder. Expected frame beats
//                are queued when a command is issued and compared as beats
//                transfer on the output interface.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_builder;

    localparam logic [7:0] c_SRC = 8'h3C;
    localparam int         c_TMO = 400;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [7:0]  cmd_dest;
    logic [7:0]  cmd_len;
    logic        cmd_ready;
    logic [7:0]  pl_data;
    logic        pl_valid;
    logic        pl_ready;
    logic [7:0]  out_data;
    logic        out_sof;
    logic        out_eof;
    logic        out_src_rdy;
    logic        out_dst_rdy;
    logic [15:0] frame_cnt;

    frame_builder #(.SRC_ADDR(c_SRC)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_dest    (cmd_dest),
        .cmd_len     (cmd_len),
        .cmd_ready   (cmd_ready),
        .pl_data     (pl_data),
        .pl_valid    (pl_valid),
        .pl_ready    (pl_ready),
        .out_data    (out_data),
        .out_sof     (out_sof),
        .out_eof     (out_eof),
        .out_src_rdy (out_src_rdy),
        .out_dst_rdy (out_dst_rdy),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [9:0] exp_q[$];     // {sof, eof, data}
    logic [7:0] pl_src[$];    // payload bytes still to feed
    int         sof_cycs[$];
    int         eof_cycs[$];
    int         cyc = 0;
    int         exp_frames = 0;
    int         bubble_at = -1;
    bit         bp_mode = 0;
    bit         pl_watch = 0;
    int         pl_seen = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Queue the full expected frame and its payload bytes.
    task automatic add_frame(input logic [7:0] dest, input logic [7:0] len, input logic [7:0] seed);
        logic [7:0] cs;
        logic [7:0] b;
        cs = dest ^ c_SRC ^ len;
        exp_q.push_back({2'b10, dest});
        exp_q.push_back({2'b00, c_SRC});
        exp_q.push_back({2'b00, len});
        for (int i = 0; i < int'(len); i++) begin
            b = seed + 8'(i);
            cs = cs ^ b;
            exp_q.push_back({2'b00, b});
            pl_src.push_back(b);
        end
        exp_q.push_back({2'b01, cs});
        exp_frames++;
    endtask

    task automatic drive_cmd(input logic [7:0] d, input logic [7:0] l);
        int t;
        cmd_valid = 1'b1;
        cmd_dest  = d;
        cmd_len   = l;
        t = 0;
        while (1) begin
            @(negedge clk);
            if (cmd_ready) break;
            t++;
            if (t > c_TMO) begin
                check_val("cmd_timeout", 32'd0, 32'd1);
                cmd_valid = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check_val("sof_latency", {out_src_rdy, out_sof, out_data}, {1'b1, 1'b1, d});
    endtask

    task automatic drive_pl();
        int t;
        int idx;
        idx = 0;
        while (pl_src.size() > 0) begin
            if (idx == bubble_at) begin
                pl_valid = 1'b0;
                @(posedge clk); #1;
                @(posedge clk); #1;
                check_val("bubble_drop", out_src_rdy, 1'b0);
            end
            pl_valid = 1'b1;
            pl_data  = pl_src[0];
            t = 0;
            while (1) begin
                @(negedge clk);
                if (pl_ready) break;
                t++;
                if (t > c_TMO) begin
                    check_val("pl_timeout", 32'd0, 32'd1);
                    pl_valid = 1'b0;
                    pl_src.delete();
                    return;
                end
            end
            @(posedge clk); #1;
            void'(pl_src.pop_front());
            idx++;
        end
        pl_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || out_src_rdy) && t < c_TMO) begin
            @(posedge clk); #1;
            t++;
        end
        check_val("drain_left", exp_q.size(), 32'd0);
    endtask

    // Backpressure generator: always ready, or a repeating 1,0,0,1,0,1 pattern.
    initial begin
        logic [5:0] pat;
        int k;
        pat = 6'b101001;  // bit k gives ready for step k
        k = 0;
        out_dst_rdy = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (bp_mode) begin
                out_dst_rdy = pat[k];
                k = (k + 1) % 6;
            end
        end
    end

    // Output monitor and scoreboard.
    initial begin
        logic [10:0] held;
        bit          stalled;
        logic [9:0]  e;
        stalled = 0;
        held = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                stalled = 0;
            end else begin
                if (stalled)
                    check_val("stall_hold", {out_src_rdy, out_sof, out_eof, out_data}, held);
                if (pl_watch && pl_ready) pl_seen++;
                if (out_src_rdy && out_dst_rdy) begin
                    if (exp_q.size() == 0) begin
                        check_val("extra_beat", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check_val("beat", {out_sof, out_eof, out_data}, e);
                    end
                    if (out_sof) sof_cycs.push_back(cyc);
                    if (out_eof) eof_cycs.push_back(cyc);
                end
                stalled = out_src_rdy && !out_dst_rdy;
                held = {out_src_rdy, out_sof, out_eof, out_data};
            end
        end
    end

    initial begin
        int t;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_dest = 8'h00;
        cmd_len = 8'h00;
        pl_data = 8'h00;
        pl_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("rst_out", {out_src_rdy, out_sof, out_eof, out_data}, 11'h000);
        check_val("rst_cnt", frame_cnt, 16'd0);
        check_val("rst_cmd_ready", cmd_ready, 1'b1);
        check_val("rst_pl_ready", pl_ready, 1'b0);

        // Basic frame: A5 3C 03 01 02 03 9A
        sof_cycs.delete(); eof_cycs.delete();
        add_frame(8'hA5, 8'd3, 8'h01);
        fork drive_cmd(8'hA5, 8'd3); drive_pl(); join
        wait_drain();
        check_val("basic_cnt", frame_cnt, 32'(exp_frames));
        if (sof_cycs.size() == 1 && eof_cycs.size() == 1)
            check_val("basic_time", 32'(eof_cycs[0] - sof_cycs[0]), 32'd6);
        else
            check_val("basic_marks", 32'(sof_cycs.size() + eof_cycs.size()), 32'd2);

        // Zero length: A5 3C 00 99, no payload request
        pl_seen = 0; pl_watch = 1;
        add_frame(8'hA5, 8'd0, 8'h00);
        drive_cmd(8'hA5, 8'd0);
        wait_drain();
        pl_watch = 0;
        check_val("zero_pl_ready", pl_seen, 32'd0);
        check_val("zero_cnt", frame_cnt, 32'(exp_frames));

        // Backpressure pattern on the basic frame
        bp_mode = 1;
        add_frame(8'hA5, 8'd3, 8'h01);
        fork drive_cmd(8'hA5, 8'd3); drive_pl(); join
        wait_drain();
        bp_mode = 0;
        @(posedge clk); #1;
        out_dst_rdy = 1'b1;
        check_val("bp_cnt", frame_cnt, 32'(exp_frames));

        // Stall on the eof beat: count waits for the transfer
        out_dst_rdy = 1'b0;
        add_frame(8'h5A, 8'd0, 8'h00);
        drive_cmd(8'h5A, 8'd0);
        t = 0;
        while (!out_eof && t < c_TMO) begin
            out_dst_rdy = 1'b1;
            @(posedge clk); #1;
            out_dst_rdy = 1'b0;
            @(posedge clk); #1;
            t++;
        end
        check_val("eof_reached", {out_src_rdy, out_eof}, 2'b11);
        repeat (2) @(posedge clk);
        #1;
        check_val("eof_stall_cnt", frame_cnt, 32'(exp_frames - 1));
        out_dst_rdy = 1'b1;
        wait_drain();
        check_val("eof_done_cnt", frame_cnt, 32'(exp_frames));

        // Payload bubble after the first byte
        bubble_at = 1;
        add_frame(8'hC3, 8'd4, 8'h10);
        fork drive_cmd(8'hC3, 8'd4); drive_pl(); join
        wait_drain();
        bubble_at = -1;
        check_val("bubble_cnt", frame_cnt, 32'(exp_frames));

        // Back-to-back frames, command held valid
        sof_cycs.delete(); eof_cycs.delete();
        add_frame(8'h11, 8'd2, 8'h20);
        add_frame(8'h22, 8'd1, 8'h30);
        fork
            begin drive_cmd(8'h11, 8'd2); drive_cmd(8'h22, 8'd1); end
            drive_pl();
        join
        wait_drain();
        if (sof_cycs.size() == 2 && eof_cycs.size() == 2)
            check_val("b2b_gap", 32'(sof_cycs[1]), 32'(eof_cycs[0] + 1));
        else
            check_val("b2b_marks", 32'(sof_cycs.size() + eof_cycs.size()), 32'd4);
        check_val("b2b_cnt", frame_cnt, 32'(exp_frames));

        // Reset in the middle of the payload
        add_frame(8'h77, 8'd5, 8'h40);
        repeat (3) void'(pl_src.pop_back());
        fork drive_cmd(8'h77, 8'd5); drive_pl(); join
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        pl_src.delete();
        exp_frames = 0;
        check_val("midrst_src_rdy", out_src_rdy, 1'b0);
        check_val("midrst_cnt", frame_cnt, 16'd0);
        add_frame(8'h77, 8'd2, 8'h50);
        fork drive_cmd(8'h77, 8'd2); drive_pl(); join
        wait_drain();
        check_val("post_rst_cnt", frame_cnt, 32'(exp_frames));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_frame_builder
`default_nettype wire
